// File: rtl/bus_master_if_pkg.sv
// -----------------------------------------------------------------------------
// bus_master_if_pkg
// Shared definitions for the CPU-to-bus master bridge:
//   - bus widths (data / address / slave select)
//   - position of the region field in the byte address and the region count
//   - FSM state encoding (binary)
//   - helper function telling whether a region maps to a slave
// -----------------------------------------------------------------------------
package bus_master_if_pkg;

    localparam int WB_DATA_BUS   = 32;
    localparam int WB_ADDR_BUS   = 32;
    localparam int WB_SELECT_BUS = 16;

    // Region field = top nibble of the byte address
    localparam int REGION_MSB   = 31;
    localparam int REGION_LSB   = 28;
    localparam int REGION_W     = REGION_MSB - REGION_LSB + 1;
    localparam int REGION_COUNT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    // Regions below REGION_COUNT have a slave behind them; the rest are holes
    function automatic logic region_mapped(input logic [REGION_W-1:0] region);
        return (region < REGION_W'(REGION_COUNT));
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// -----------------------------------------------------------------------------
// bus_addr_decode
// Purely combinational address decoder.
// Ports:
//   i_addr      in  32  byte address
//   o_select    out 16  one-hot slave select (bits above REGION_COUNT-1 stay 0)
//   o_unmapped  out 1   address falls in a region with no slave
// -----------------------------------------------------------------------------
module bus_addr_decode
    import bus_master_if_pkg::*;
(
    input  logic [WB_ADDR_BUS-1:0]   i_addr,
    output logic [WB_SELECT_BUS-1:0] o_select,
    output logic                     o_unmapped
);

    logic [REGION_W-1:0]   w_region;
    logic [REGION_LSB-1:0] w_unused_offset;

    assign w_region        = i_addr[REGION_MSB:REGION_LSB];
    assign w_unused_offset = i_addr[REGION_LSB-1:0];

    // Region to one-hot select, or flag the hole
    always_comb begin
        o_select   = {WB_SELECT_BUS{1'b0}};
        o_unmapped = 1'b1;
        if (region_mapped(w_region)) begin
            o_select[w_region] = 1'b1;
            o_unmapped         = 1'b0;
        end else begin
            o_select   = {WB_SELECT_BUS{1'b0}};
            o_unmapped = 1'b1;
        end
    end

endmodule

// File: rtl/bus_master_if.sv
// -----------------------------------------------------------------------------
// bus_master_if
// Bridges a stalling CPU memory port onto a 1-master/8-slave bus.
// Every access walks IDLE -> REQ -> WAIT -> DONE; unmapped accesses jump
// straight from IDLE to DONE with an error. Optional watchdog on WAIT is
// compiled in with the BUS_TIMEOUT_EN macro (TIMEOUT_CYCLES WAIT cycles).
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cpu_req_i/addr/we/data_i   CPU request (held until cpu_stall_o drops)
//   cpu_data_o, cpu_err_o      result, valid during the DONE cycle
//   cpu_stall_o                combinational pipeline hold
//   m_addr_o/m_data_o/m_we_o   registered bus request
//   m_select_o                 one-hot slave select, nonzero only in REQ/WAIT
//   m_data_i, m_ack_i          bus response
// -----------------------------------------------------------------------------
module bus_master_if
    import bus_master_if_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_req_i,
    input  logic [WB_ADDR_BUS-1:0]   cpu_addr_i,
    input  logic                     cpu_we_i,
    input  logic [WB_DATA_BUS-1:0]   cpu_data_i,
    output logic [WB_DATA_BUS-1:0]   cpu_data_o,
    output logic                     cpu_stall_o,
    output logic                     cpu_err_o,
    output logic [WB_ADDR_BUS-1:0]   m_addr_o,
    output logic [WB_DATA_BUS-1:0]   m_data_o,
    output logic                     m_we_o,
    output logic [WB_SELECT_BUS-1:0] m_select_o,
    input  logic [WB_DATA_BUS-1:0]   m_data_i,
    input  logic                     m_ack_i
);

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [WB_SELECT_BUS-1:0] r_select;
    logic [WB_SELECT_BUS-1:0] w_dec_select;
    logic                     w_dec_unmapped;
    logic [WB_ADDR_BUS-1:0]   r_addr;
    logic [WB_DATA_BUS-1:0]   r_wdata;
    logic [WB_DATA_BUS-1:0]   r_rdata;
    logic                     r_we;
    logic                     r_err;
    logic                     r_ack_seen;
    logic                     w_load;
    logic                     w_unmapped_hit;
    logic                     w_capture;
    logic                     w_timeout;

`ifdef BUS_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_wait_cnt;
`else
    logic [7:0] w_unused_timeout;
    assign w_unused_timeout = 8'(TIMEOUT_CYCLES);
`endif

    bus_addr_decode u_decode (
        .i_addr     (cpu_addr_i),
        .o_select   (w_dec_select),
        .o_unmapped (w_dec_unmapped)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath strobes
    always_comb begin
        w_state_nxt    = r_state;
        w_load         = 1'b0;
        w_unmapped_hit = 1'b0;
        w_capture      = 1'b0;
        w_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (w_dec_unmapped) begin
                        w_unmapped_hit = 1'b1;
                        w_state_nxt    = ST_DONE;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = ST_REQ;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            // REQ exists so select is stable one cycle before the read mux
            // (which uses a delayed select) is sampled in WAIT.
            ST_REQ: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (r_ack_seen || m_ack_i) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
`ifdef BUS_TIMEOUT_EN
                else if (r_wait_cnt == TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_DONE;
                end
`endif
                else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus request, select, ack tracking and CPU result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_we       <= 1'b0;
            r_select   <= 16'h0000;
            r_rdata    <= 32'h0000_0000;
            r_err      <= 1'b0;
            r_ack_seen <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_addr     <= cpu_addr_i;
                        r_wdata    <= cpu_data_i;
                        r_we       <= cpu_we_i;
                        r_select   <= w_dec_select;
                        r_ack_seen <= 1'b0;
                    end else if (w_unmapped_hit) begin
                        r_rdata <= 32'h0000_0000;
                        r_err   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (m_ack_i) begin
                        r_ack_seen <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (w_capture) begin
                        r_rdata  <= r_we ? 32'h0000_0000 : m_data_i;
                        r_err    <= 1'b0;
                        r_select <= 16'h0000;
                    end else if (w_timeout) begin
                        r_rdata  <= 32'h0000_0000;
                        r_err    <= 1'b1;
                        r_select <= 16'h0000;
                    end
                end
                // Error is a one-cycle pulse aligned with DONE
                ST_DONE: r_err <= 1'b0;
                default: r_select <= 16'h0000;
            endcase
        end
    end

`ifdef BUS_TIMEOUT_EN
    // WAIT watchdog: cleared when a request is launched, counts WAIT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (w_load) begin
            r_wait_cnt <= 8'd0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end
`endif

    assign cpu_stall_o = cpu_req_i & (r_state != ST_DONE);
    assign cpu_data_o  = r_rdata;
    assign cpu_err_o   = r_err;
    assign m_addr_o    = r_addr;
    assign m_data_o    = r_wdata;
    assign m_we_o      = r_we;
    assign m_select_o  = r_select;

endmodule

// File: tb/tb_bus_master_if.sv
// -----------------------------------------------------------------------------
// tb_bus_master_if
// Directed checks of bus_master_if: reset values, read/write timing, unmapped
// access, back-to-back requests, request drop, endless wait (or watchdog when
// BUS_TIMEOUT_EN is defined) and reset asserted in WAIT.
// -----------------------------------------------------------------------------
module tb_bus_master_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_we_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        cpu_stall_o;
    logic        cpu_err_o;
    logic [31:0] m_addr_o;
    logic [31:0] m_data_o;
    logic        m_we_o;
    logic [15:0] m_select_o;
    logic [31:0] m_data_i;
    logic        m_ack_i;

    int n_checks = 0;
    int n_pass   = 0;

    bus_master_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cpu_req_i   (cpu_req_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_we_i    (cpu_we_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .cpu_err_o   (cpu_err_o),
        .m_addr_o    (m_addr_o),
        .m_data_o    (m_data_o),
        .m_we_o      (m_we_o),
        .m_select_o  (m_select_o),
        .m_data_i    (m_data_i),
        .m_ack_i     (m_ack_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Move to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int stall_low;
        rst_n      = 1'b0;
        cpu_req_i  = 1'b0;
        cpu_addr_i = 32'h0000_0000;
        cpu_we_i   = 1'b0;
        cpu_data_i = 32'h0000_0000;
        m_data_i   = 32'h0000_0000;
        m_ack_i    = 1'b0;

        // ---------------- reset values ----------------
        #3;
        chk("rst_sel",   32'(m_select_o), 32'h0000_0000);
        chk("rst_we",    32'(m_we_o),     32'd0);
        chk("rst_addr",  m_addr_o,        32'h0000_0000);
        chk("rst_mdata", m_data_o,        32'h0000_0000);
        chk("rst_cdata", cpu_data_o,      32'h0000_0000);
        chk("rst_err",   32'(cpu_err_o),  32'd0);
        chk("rst_stall", 32'(cpu_stall_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- read, slave 2 acks in first select cycle ----------------
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h2000_0010;
        cpu_we_i   = 1'b0;
        m_data_i   = 32'hDEAD_BEEF;
        #1;
        chk("rd_idle_stall", 32'(cpu_stall_o), 32'd1);
        chk("rd_idle_sel",   32'(m_select_o),  32'h0000_0000);
        tick();                                  // REQ
        m_ack_i = 1'b1;
        #1;
        chk("rd_req_sel",   32'(m_select_o),  32'h0000_0004);
        chk("rd_req_stall", 32'(cpu_stall_o), 32'd1);
        chk("rd_req_addr",  m_addr_o,         32'h2000_0010);
        chk("rd_req_we",    32'(m_we_o),      32'd0);
        tick();                                  // WAIT (ack remembered)
        m_ack_i = 1'b0;
        #1;
        chk("rd_wait_sel",   32'(m_select_o),  32'h0000_0004);
        chk("rd_wait_stall", 32'(cpu_stall_o), 32'd1);
        tick();                                  // DONE
        #1;
        chk("rd_done_stall", 32'(cpu_stall_o), 32'd0);
        chk("rd_done_sel",   32'(m_select_o),  32'h0000_0000);
        chk("rd_done_data",  cpu_data_o,       32'hDEAD_BEEF);
        chk("rd_done_err",   32'(cpu_err_o),   32'd0);
        tick();                                  // IDLE
        cpu_req_i = 1'b0;
        m_data_i  = 32'h0000_0000;
        #1;
        chk("rd_after_stall", 32'(cpu_stall_o), 32'd0);
        chk("rd_after_hold",  cpu_data_o,       32'hDEAD_BEEF);

        // ---------------- write, slave 7 acks after 5 cycles ----------------
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h7000_0000;
        cpu_we_i   = 1'b1;
        cpu_data_i = 32'h1234_5678;
        m_data_i   = 32'hFFFF_FFFF;
        tick();                                  // REQ
        #1;
        chk("wr_req_sel",   32'(m_select_o), 32'h0000_0080);
        chk("wr_req_we",    32'(m_we_o),     32'd1);
        chk("wr_req_mdata", m_data_o,        32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            tick();                              // WAIT, no ack
            #1;
            chk("wr_wait_sel",   32'(m_select_o),  32'h0000_0080);
            chk("wr_wait_stall", 32'(cpu_stall_o), 32'd1);
            chk("wr_wait_mdata", m_data_o,         32'h1234_5678);
        end
        tick();                                  // WAIT, ack arrives
        m_ack_i = 1'b1;
        #1;
        chk("wr_ack_stall", 32'(cpu_stall_o), 32'd1);
        tick();                                  // DONE
        m_ack_i = 1'b0;
        #1;
        chk("wr_done_stall", 32'(cpu_stall_o), 32'd0);
        chk("wr_done_sel",   32'(m_select_o),  32'h0000_0000);
        chk("wr_done_we",    32'(m_we_o),      32'd1);
        chk("wr_done_mdata", m_data_o,         32'h1234_5678);
        chk("wr_done_data",  cpu_data_o,       32'h0000_0000);
        chk("wr_done_err",   32'(cpu_err_o),   32'd0);
        tick();                                  // IDLE
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        #1;
        chk("wr_idle_sel", 32'(m_select_o), 32'h0000_0000);

        // ---------------- unmapped access ----------------
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h9000_0000;
        m_ack_i    = 1'b1;                       // interconnect ack for zero select
        #1;
        chk("um_idle_stall", 32'(cpu_stall_o), 32'd1);
        tick();                                  // DONE
        #1;
        chk("um_done_stall", 32'(cpu_stall_o), 32'd0);
        chk("um_done_sel",   32'(m_select_o),  32'h0000_0000);
        chk("um_done_err",   32'(cpu_err_o),   32'd1);
        chk("um_done_data",  cpu_data_o,       32'h0000_0000);
        tick();                                  // IDLE
        cpu_req_i = 1'b0;
        #1;
        chk("um_err_pulse", 32'(cpu_err_o), 32'd0);

        // ---------------- back-to-back: slave 1 then slave 3 ----------------
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h1000_0000;
        m_data_i   = 32'hAAAA_0001;
        tick();                                  // REQ
        #1;
        chk("bb1_req_sel", 32'(m_select_o), 32'h0000_0002);
        tick();                                  // WAIT
        #1;
        chk("bb1_wait_sel", 32'(m_select_o), 32'h0000_0002);
        tick();                                  // DONE
        cpu_addr_i = 32'h3000_0000;
        m_data_i   = 32'hBBBB_0003;
        #1;
        chk("bb1_done_sel",  32'(m_select_o), 32'h0000_0000);
        chk("bb1_done_data", cpu_data_o,      32'hAAAA_0001);
        tick();                                  // IDLE, one cycle
        #1;
        chk("bb_idle_sel",   32'(m_select_o),  32'h0000_0000);
        chk("bb_idle_stall", 32'(cpu_stall_o), 32'd1);
        tick();                                  // REQ
        #1;
        chk("bb2_req_sel", 32'(m_select_o), 32'h0000_0008);
        tick();                                  // WAIT
        tick();                                  // DONE
        #1;
        chk("bb2_done_data",  cpu_data_o,       32'hBBBB_0003);
        chk("bb2_done_stall", 32'(cpu_stall_o), 32'd0);
        tick();
        cpu_req_i = 1'b0;
        m_ack_i   = 1'b0;

        // ---------------- request dropped mid-transaction ----------------
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h4000_0000;
        m_data_i   = 32'h5555_5555;
        tick();                                  // REQ
        cpu_req_i = 1'b0;
        #1;
        chk("drop_req_sel",   32'(m_select_o),  32'h0000_0010);
        chk("drop_req_stall", 32'(cpu_stall_o), 32'd0);
        tick();                                  // WAIT
        m_ack_i = 1'b1;
        #1;
        chk("drop_wait_sel", 32'(m_select_o), 32'h0000_0010);
        tick();                                  // DONE
        m_ack_i = 1'b0;
        #1;
        chk("drop_done_data", cpu_data_o, 32'h5555_5555);
        tick();                                  // IDLE
        #1;
        chk("drop_idle_sel", 32'(m_select_o), 32'h0000_0000);

        // ---------------- slave never acks ----------------
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h5000_0000;
        tick();                                  // REQ
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();                              // WAIT 1..4
            #1;
            chk("to_wait_stall", 32'(cpu_stall_o), 32'd1);
        end
        tick();                                  // DONE by watchdog
        #1;
        chk("to_done_stall", 32'(cpu_stall_o), 32'd0);
        chk("to_done_err",   32'(cpu_err_o),   32'd1);
        chk("to_done_data",  cpu_data_o,       32'h0000_0000);
        tick();
        cpu_req_i = 1'b0;
        tick();
        cpu_req_i  = 1'b1;                       // fresh access parked in WAIT
        cpu_addr_i = 32'h6000_0000;
        tick();                                  // REQ
        tick();                                  // WAIT
`else
        stall_low = 0;
        for (int i = 0; i < 110; i++) begin
            tick();
            if (cpu_stall_o !== 1'b1) stall_low++;
        end
        chk("nto_stall_low_cnt", 32'(stall_low),  32'd0);
        chk("nto_sel",           32'(m_select_o), 32'h0000_0020);
`endif

        // ---------------- reset asserted in WAIT ----------------
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_sel",   32'(m_select_o), 32'h0000_0000);
        chk("rstw_addr",  m_addr_o,        32'h0000_0000);
        chk("rstw_cdata", cpu_data_o,      32'h0000_0000);
        tick();
        cpu_req_i = 1'b0;
        rst_n     = 1'b1;
        tick();
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0000;
        m_data_i   = 32'h0BAD_F00D;
        m_ack_i    = 1'b1;
        tick();                                  // REQ
        #1;
        chk("post_req_sel", 32'(m_select_o), 32'h0000_0001);
        tick();                                  // WAIT
        tick();                                  // DONE
        #1;
        chk("post_done_stall", 32'(cpu_stall_o), 32'd0);
        chk("post_done_data",  cpu_data_o,       32'h0BAD_F00D);
        chk("post_done_err",   32'(cpu_err_o),   32'd0);
        tick();
        cpu_req_i = 1'b0;
        m_ack_i   = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bus_master_if.md
BUS_MASTER_IF -- requirements
Module: bus_master_if

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum WAIT-state cycles before a watchdog abort (8-bit counter).
REQ-002 Clock and reset are fixed: one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
REQ-003 CPU-side ports:
- cpu_req_i  in  1  memory access request, held until stall drops.
- cpu_addr_i  in  32  byte address.
- cpu_we_i  in  1  1 = write.
- cpu_data_i  in  32  write data.
- cpu_data_o  out  32  read data.
- cpu_stall_o  out  1  pipeline hold.
- cpu_err_o  out  1  access error pulse.
REQ-004 Bus-side ports, feeding the 1-master/8-slave bus interconnect:
- m_addr_o  out  32
- m_data_o  out  32
- m_we_o  out  1
- m_select_o  out  16  one-hot slave select.
- m_data_i  in  32
- m_ack_i  in  1

Function
REQ-005 Address decode: region = cpu_addr_i[31:28].
- Region 0..7 sets m_select_o bit [region].
- Region 8..15 is unmapped.
- Bits [15:8] of m_select_o are always 0.
REQ-006 The FSM states are IDLE, REQ, WAIT and DONE, with one-hot or binary encoding taken from the shared defines.
REQ-007 IDLE transitions:
- On cpu_req_i=1 with a mapped region, register m_addr_o, m_data_o and m_we_o, then go to REQ.
- On cpu_req_i=1 with an unmapped region, go directly to DONE with error flagged and read data 0.
REQ-008 m_select_o is nonzero only in REQ and WAIT. It is 0 in IDLE and DONE.
- The interconnect returns ack=1 for a zero select, so m_ack_i is ignored outside REQ and WAIT.
REQ-009 REQ state: hold select. If m_ack_i=1, set ack_seen. Always go to WAIT.
- This guarantees select has been stable for at least 1 cycle before data capture, because the interconnect's read mux uses a 1-cycle-delayed select.
REQ-010 WAIT state: if ack_seen=1 or m_ack_i=1, capture m_data_i (reads only; writes capture 0) and go to DONE. Otherwise stay.
REQ-011 DONE state: cpu_stall_o=0 for exactly 1 cycle, cpu_data_o is valid, and cpu_err_o reflects the error flag; then go to IDLE.
REQ-012 cpu_stall_o = cpu_req_i AND (state != DONE). The signal is combinational.
REQ-013 Minimum latency for a zero-wait slave is 3 stall cycles followed by the DONE cycle.
REQ-014 m_addr_o, m_data_o and m_we_o hold constant from REQ through DONE. cpu_data_o holds its value until the next capture.
REQ-015 cpu_req_i dropping mid-transaction does not abort. The transaction completes and its result is discarded.

Reset
REQ-016 While rst_n=0, the block asynchronously forces:
- state=IDLE
- m_select_o=0, m_we_o=0, m_addr_o=0, m_data_o=0
- cpu_data_o=0, cpu_err_o=0
- ack_seen=0, timeout counter=0
REQ-017 Reset asserted mid-transaction drops m_select_o to 0 within the same cycle, without waiting for a clock edge. There is no partial completion.

Configuration
REQ-018 Macro BUS_TIMEOUT_EN, when defined:
- WAIT counts cycles.
- When the count reaches TIMEOUT_CYCLES with no ack, the block goes to DONE with cpu_err_o=1 and cpu_data_o=0.
- The counter clears on entry to REQ.
REQ-019 When BUS_TIMEOUT_EN is undefined, WAIT persists indefinitely, no counter logic exists, and cpu_err_o is driven only by unmapped accesses.

Structure
REQ-020 State encoding, region field position, the region count (8) and the WB_DataBus/WB_AddrBus/WB_SelectBus widths (32/32/16) reside in the shared defines file.
REQ-021 The decode logic is a combinational sub-module, bus_addr_decode: address in; 16-bit one-hot select and an unmapped flag out.

Verification
REQ-022 Read, addr 0x2000_0010, slave 2 acks in its first select cycle with 0xDEAD_BEEF → m_select_o=16'h0004 for 2 cycles, 3 stall cycles, DONE with cpu_data_o=0xDEAD_BEEF, cpu_err_o=0.
REQ-023 Write, addr 0x7000_0000, data 0x1234_5678, slave 7 acks after 5 cycles → m_we_o=1 and m_data_o=0x1234_5678 held throughout, select 16'h0080, single DONE cycle.
REQ-024 Access to 0x9000_0000 → m_select_o stays 0, DONE on the next cycle with cpu_err_o=1 and cpu_data_o=0.
REQ-025 With BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks → DONE after 4 WAIT cycles with cpu_err_o=1. Without the macro, stall persists for 100+ cycles.
REQ-026 rst_n pulled low during WAIT → m_select_o=0 immediately. After release, a new read to 0x0000_0000 completes normally.
REQ-027 Two back-to-back requests (slaves 1 then 3) → IDLE for exactly 1 cycle between them, with the select sequence 0x0002, 0x0000, 0x0008.
